// File: rtl/seq_mul_n_if.sv
// -----------------------------------------------------------------------------
// seq_mul_n_if
//
// Purpose:
//   Groups the request/response signals of the sequential multiplier so the
//   requester and the multiplier connect through one bundle. The clock and the
//   reset are not part of the bundle; they stay plain ports on the multiplier.
//
// Parameters:
//   WIDTH    operand width in bits; the product is 2*WIDTH bits.
//
// Signals:
//   start    request, accepted only on an edge where busy is 0
//   x        multiplicand, sampled on the accepting edge
//   y        multiplier, sampled on the accepting edge
//   sgn      signed-mode select, sampled on the accepting edge
//   busy     high while an operation is in progress
//   done     one-cycle pulse: product is valid and newly updated
//   product  result register, holds until the next completion
//
// Modports:
//   master   the requester: drives start/x/y/sgn, observes busy/done/product
//   slave    the multiplier: observes start/x/y/sgn, drives busy/done/product
// -----------------------------------------------------------------------------
interface seq_mul_n_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 sgn;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output x,
        output y,
        output sgn,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  x,
        input  y,
        input  sgn,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mul_n.sv
// -----------------------------------------------------------------------------
// seq_mul_n
//
// Purpose:
//   Parametrised sequential shift-add multiplier. Two WIDTH-bit operands are
//   accepted under a start/busy/done handshake; one multiplier bit is retired
//   per clock through a single 2*WIDTH-bit adder, and the 2*WIDTH-bit product
//   is published after exactly WIDTH RUN cycles, independent of the operands.
//
// Parameters:
//   WIDTH    operand width in bits (>= 2); product is 2*WIDTH bits
//   CNT_W    iteration counter width, derived as $clog2(WIDTH+1)
//
// Ports:
//   clk      single system clock, all state updates on the rising edge
//   rst_n    synchronous active-low reset, sampled on the rising edge of clk
//   bus      seq_mul_n_if slave modport:
//              start/x/y/sgn in, busy/done/product out
//
// Optional feature (compile-time macro SEQ_MUL_SIGNED_EN):
//   Defined     : sgn=1 at acceptance treats x and y as two's complement. The
//                 magnitudes are multiplied by the same unsigned loop and the
//                 final accumulator is negated when the operand signs differ.
//   Not defined : sgn is ignored; every operation is unsigned and no sign
//                 flag or negation logic exists.
//
// Timing (acceptance on edge k):
//   busy is high after edge k until edge k+WIDTH; done is high for the single
//   cycle after edge k+WIDTH, which is also an IDLE cycle, so a new request
//   can be accepted while done is showing.
// -----------------------------------------------------------------------------
module seq_mul_n #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_mul_n_if.slave  bus
);

    localparam int PW = 2 * WIDTH;

    // Counter value seen on the final RUN edge; that edge takes it to WIDTH.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers with their next-state values
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      r_mcand;
    logic [PW-1:0]      w_mcand_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [PW-1:0]      r_product;
    logic [PW-1:0]      w_product_next;
    logic               r_done;
    logic               w_done_next;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic [PW-1:0]      w_addend;   // multiplicand gated by the current bit
    logic [PW-1:0]      w_acc_sum;  // accumulator after this edge's step
    logic [PW-1:0]      w_result;   // value published on the completion edge
    logic [WIDTH-1:0]   w_load_x;   // operand images captured at acceptance
    logic [WIDTH-1:0]   w_load_y;
    logic               w_last;

    // Each multiplicand bit is ANDed with the multiplier LSB, giving either
    // the shifted multiplicand or zero as the single adder's second input.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi = gi + 1) begin : g_addend
            assign w_addend[gi] = r_mcand[gi] & r_mplier[0];
        end
    endgenerate

    // The multiplicand never exceeds 2*WIDTH bits after WIDTH-1 shifts and the
    // running sum is bounded by (2^WIDTH-1)^2, so this add cannot overflow.
    assign w_acc_sum = r_acc + w_addend;
    assign w_last    = (r_cnt == LAST_CNT);

`ifdef SEQ_MUL_SIGNED_EN
    // ---------------------------------------------------------------------
    // Signed mode: the loop always runs on magnitudes. Negating a WIDTH-bit
    // value modulo 2^WIDTH maps the most negative operand -2^(WIDTH-1) onto
    // the unsigned pattern 2^(WIDTH-1), which is exactly its magnitude, so
    // no extra bit is needed for the operand registers.
    // ---------------------------------------------------------------------
    logic               r_neg;
    logic               w_neg_next;
    logic               w_x_neg;
    logic               w_y_neg;
    logic               w_load_neg;

    assign w_x_neg    = bus.sgn & bus.x[WIDTH-1];
    assign w_y_neg    = bus.sgn & bus.y[WIDTH-1];
    assign w_load_x   = w_x_neg ? -bus.x : bus.x;
    assign w_load_y   = w_y_neg ? -bus.y : bus.y;
    assign w_load_neg = w_x_neg ^ w_y_neg;

    // A zero product with differing signs negates to zero, which is correct.
    assign w_result   = r_neg ? -w_acc_sum : w_acc_sum;
`else
    // Unsigned-only build: sgn is accepted on the bus but has no effect.
    logic               w_unused_sgn;

    assign w_unused_sgn = bus.sgn;
    assign w_load_x     = bus.x;
    assign w_load_y     = bus.y;
    assign w_result     = w_acc_sum;
`endif

    // -------------------------------------------------------------------------
    // Next-state / next-datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_acc_next     = r_acc;
        w_mcand_next   = r_mcand;
        w_mplier_next  = r_mplier;
        w_product_next = r_product;
        // done is a pulse: it drops on every edge unless re-raised below.
        w_done_next    = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
        w_neg_next     = r_neg;
`endif

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next  = S_RUN;
                    w_mcand_next  = {{WIDTH{1'b0}}, w_load_x};
                    w_mplier_next = w_load_y;
                    w_acc_next    = '0;
                    w_cnt_next    = '0;
`ifdef SEQ_MUL_SIGNED_EN
                    w_neg_next    = w_load_neg;
`endif
                end
            end

            S_RUN: begin
                // start is not looked at here: requests while busy are
                // dropped and the operands in flight are untouched.
                w_acc_next    = w_acc_sum;
                w_mcand_next  = {r_mcand[PW-2:0], 1'b0};
                w_mplier_next = {1'b0, r_mplier[WIDTH-1:1]};
                w_cnt_next    = r_cnt + CNT_W'(1);
                if (w_last) begin
                    // Publish the sum including this edge's partial product
                    // so the result lands on edge k+WIDTH, not one later.
                    w_product_next = w_result;
                    w_done_next    = 1'b1;
                    w_state_next   = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register with synchronous active-low reset. A reset in mid
    // operation simply drops everything, so no done pulse can follow it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
            r_neg     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_acc     <= w_acc_next;
            r_mcand   <= w_mcand_next;
            r_mplier  <= w_mplier_next;
            r_product <= w_product_next;
            r_done    <= w_done_next;
`ifdef SEQ_MUL_SIGNED_EN
            r_neg     <= w_neg_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all straight from registers
    // -------------------------------------------------------------------------
    assign bus.busy    = (r_state == S_RUN);
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mul_n.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_n
//
// Self-checking bench for seq_mul_n. Two instances (WIDTH=4 and WIDTH=8) share
// clock and reset; directed cases are followed by randomized operations. The
// reference is plain integer multiplication of the operand values.
// -----------------------------------------------------------------------------
module tb_seq_mul_n;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [15:0] prev4;   // last product published by the WIDTH=4 instance
    logic [15:0] prev8;   // last product published by the WIDTH=8 instance

    seq_mul_n_if #(.WIDTH(4)) bus4 ();
    seq_mul_n_if #(.WIDTH(8)) bus8 ();

    seq_mul_n #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seq_mul_n #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference product: integer multiply; in signed mode the operands are
    // read as two's complement values first, result kept to 2*w bits.
    function automatic logic [15:0] model(input int w, input logic [7:0] xa,
                                          input logic [7:0] ya, input logic s);
        longint xv, yv, pr, m;
        m  = longint'(1) << w;
        xv = longint'(xa) % m;
        yv = longint'(ya) % m;
`ifdef SEQ_MUL_SIGNED_EN
        if (s) begin
            if (xv >= m / 2) xv = xv - m;
            if (yv >= m / 2) yv = yv - m;
        end
`else
        if (s) pr = 0;  // sgn has no meaning in the unsigned build
`endif
        pr = xv * yv;
        pr = pr & ((longint'(1) << (2 * w)) - 1);
        return 16'(pr);
    endfunction

    task automatic drive(input int w, input logic st, input logic [7:0] xa,
                         input logic [7:0] ya, input logic s);
        if (w == 4) begin
            bus4.start = st; bus4.x = xa[3:0]; bus4.y = ya[3:0]; bus4.sgn = s;
        end else begin
            bus8.start = st; bus8.x = xa; bus8.y = ya; bus8.sgn = s;
        end
    endtask

    task automatic sample(input int w, output logic b, output logic d, output logic [15:0] p);
        if (w == 4) begin
            b = bus4.busy; d = bus4.done; p = {8'h00, bus4.product};
        end else begin
            b = bus8.busy; d = bus8.done; p = bus8.product;
        end
    endtask

    // Called at a negedge with the DUT idle. Accepts on the next posedge (k),
    // then checks every cycle up to and including the done cycle. With stray
    // set, start is held high with x=y=1 across edges k+1..k+3.
    task automatic run_op(input int w, input logic [7:0] xa, input logic [7:0] ya,
                          input logic s, input bit stray);
        logic [15:0] expv, prevv, p;
        logic b, d;
        expv  = model(w, xa, ya, s);
        prevv = (w == 4) ? prev4 : prev8;
        drive(w, 1'b1, xa, ya, s);
        @(posedge clk);
        for (int j = 0; j <= w; j++) begin
            @(negedge clk);
            sample(w, b, d, p);
            check("busy_done", {62'd0, b, d}, (j < w) ? 64'd2 : 64'd1);
            check("product", {48'd0, p}, {48'd0, (j == w) ? expv : prevv});
            if (stray && j < 3) drive(w, 1'b1, 8'h01, 8'h01, 1'b0);
            else                drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        if (w == 4) prev4 = expv; else prev8 = expv;
        $display("op w=%0d x=%0h y=%0h sgn=%0d stray=%0d product=%0h expected=%0h",
                 w, xa, ya, s, stray, p, expv);
    endtask

    // One idle cycle: no busy, no done, product held.
    task automatic idle_check(input int w);
        logic [15:0] p;
        logic b, d;
        @(negedge clk);
        sample(w, b, d, p);
        check("idle_busy_done", {62'd0, b, d}, 64'd0);
        check("idle_product", {48'd0, p}, {48'd0, (w == 4) ? prev4 : prev8});
    endtask

    function automatic logic [7:0] pick(input int w);
        int sel;
        logic [7:0] mx;
        sel = $urandom_range(0, 5);
        mx  = (w == 4) ? 8'h0F : 8'hFF;
        case (sel)
            0:       return 8'h00;
            1:       return mx;
            2:       return (w == 4) ? 8'h08 : 8'h80;
            default: return 8'($urandom) & mx;
        endcase
    endfunction

    initial begin
        logic b, d;
        logic [15:0] p;
        int w;
        n_checks = 0;
        n_fail   = 0;
        prev4    = '0;
        prev8    = '0;
        rst_n    = 1'b0;
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state of both instances
        sample(4, b, d, p);
        check("rst4_busy_done", {62'd0, b, d}, 64'd0);
        check("rst4_product", {48'd0, p}, 64'd0);
        sample(8, b, d, p);
        check("rst8_busy_done", {62'd0, b, d}, 64'd0);
        check("rst8_product", {48'd0, p}, 64'd0);
        rst_n = 1'b1;
        idle_check(4);

        // Zero multiplicand
        run_op(4, 8'd0, 8'd1, 1'b0, 1'b0);
        // Back-to-back: each follows in the previous done cycle
        run_op(4, 8'd2, 8'd6, 1'b0, 1'b0);
        run_op(4, 8'd6, 8'd8, 1'b0, 1'b0);
        run_op(4, 8'd12, 8'd3, 1'b0, 1'b0);
        idle_check(4);
        // Requests while busy are ignored
        run_op(4, 8'd9, 8'd9, 1'b0, 1'b1);
        idle_check(4);
        idle_check(4);

        // Reset in mid operation, asserted for edge k+2
        drive(4, 1'b1, 8'd15, 8'd15, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        sample(4, b, d, p);
        check("mid_rst_pre", {62'd0, b, d}, 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sample(4, b, d, p);
        check("mid_rst_busy_done", {62'd0, b, d}, 64'd0);
        check("mid_rst_product", {48'd0, p}, 64'd0);
        rst_n = 1'b1;
        prev4 = '0;
        prev8 = '0;
        repeat (6) idle_check(4);
        run_op(4, 8'd15, 8'd15, 1'b0, 1'b0);

        // WIDTH=8 corner
        run_op(8, 8'd255, 8'd255, 1'b0, 1'b0);
        run_op(8, 8'd0, 8'd77, 1'b0, 1'b0);

        // Signed-mode operands and the same with sgn=0
        run_op(4, 8'd12, 8'd3, 1'b1, 1'b0);
        run_op(4, 8'd8, 8'd8, 1'b1, 1'b0);
        run_op(4, 8'd12, 8'd3, 1'b0, 1'b0);
        run_op(4, 8'd8, 8'd8, 1'b0, 1'b0);
        run_op(8, 8'h80, 8'h7F, 1'b1, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 2) == 0) ? 8 : 4;
            run_op(w, pick(w), pick(w), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_check(w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
